lcd_image_streamer: RTL and testbench

Frame scanner that reads one IMG_W×IMG_H RGB565 image out of the 16-bit block ROM and delivers it, in raster order, as a valid/ready pixel stream to the LCD write controller. It sits directly between the image ROM (synchronous, one-cycle read latency, address in / data out) and the LCD bus interface. It hides the ROM latency behind a small tagged FIFO so that backpressure never loses or duplicates a pixel.

---
 rtl/lcd_image_streamer.sv | 149 ++++++++++++++
 tb/tb_lcd_image_streamer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_image_streamer.sv
// Raster-order frame scanner: reads an IMG_W x IMG_H image from a 1-cycle-latency
// ROM and emits it as a tagged valid/ready pixel stream through a 4-entry FIFO.
module lcd_image_streamer #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 16,
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] px_data,
    output logic                  px_valid,
    input  logic                  px_ready,
    output logic                  px_sof,
    output logic                  px_eol,
    output logic                  px_eof,
    output logic                  busy,
    output logic                  done
);
    localparam int X_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int Y_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_W * IMG_H - 1);
    localparam logic [X_W-1:0]        X_LAST    = X_W'(IMG_W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]            state;
    logic [X_W-1:0]        x;
    logic [Y_W-1:0]        y;
    logic                  in_flight;
    logic                  tag_sof, tag_eol, tag_eof;

    logic [DATA_WIDTH-1:0] fifo_data [4];
    logic [2:0]            fifo_tag  [4];
    logic [1:0]            wr_ptr, rd_ptr;
    logic [2:0]            fifo_count;

    logic [2:0]            occupancy;
    logic                  issue, last_issue, push, pop, head_eof;
    logic                  cur_sof, cur_eol, cur_eof;

    // Reads in flight count against FIFO space so a response always has a slot.
    assign occupancy  = fifo_count + {2'b00, in_flight};
    assign issue      = (state == S_RUN) && (occupancy <= 3'd2);
    assign last_issue = issue && (rom_addr == LAST_ADDR);
    assign push       = in_flight;
    assign pop        = px_valid && px_ready;
    assign head_eof   = fifo_tag[rd_ptr][0];

    assign cur_sof = (x == '0) && (y == '0);
    assign cur_eol = (x == X_LAST);
    assign cur_eof = (rom_addr == LAST_ADDR);

    assign px_valid = (fifo_count != 3'd0);
    assign px_data  = fifo_data[rd_ptr];
    assign px_sof   = fifo_tag[rd_ptr][2];
    assign px_eol   = fifo_tag[rd_ptr][1];
    assign px_eof   = fifo_tag[rd_ptr][0];
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE:  if (start) state <= S_RUN;
                S_RUN:   if (last_issue) state <= S_DRAIN;
                S_DRAIN: begin
                    if (pop && head_eof) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Linear address counter; x/y only track position for the line/frame tags.
    // The final address is held rather than stepped past the image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            x        <= '0;
            y        <= '0;
        end else if (state == S_IDLE && start) begin
            rom_addr <= '0;
            x        <= '0;
            y        <= '0;
        end else if (issue && !last_issue) begin
            rom_addr <= rom_addr + ADDR_WIDTH'(1);
            if (x == X_LAST) begin
                x <= '0;
                y <= y + Y_W'(1);
            end else begin
                x <= x + X_W'(1);
            end
        end
    end

    // Tags ride alongside the ROM latency so they line up with rom_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight <= 1'b0;
            tag_sof   <= 1'b0;
            tag_eol   <= 1'b0;
            tag_eof   <= 1'b0;
        end else begin
            in_flight <= issue;
            if (issue) begin
                tag_sof <= cur_sof;
                tag_eol <= cur_eol;
                tag_eof <= cur_eof;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                fifo_data[i] <= '0;
                fifo_tag[i]  <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= rom_data;
                fifo_tag[wr_ptr]  <= {tag_sof, tag_eol, tag_eof};
                wr_ptr            <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_image_streamer.sv
// Bench for lcd_image_streamer: scoreboard-checked 4x3 frames under several
// ready patterns, restart/reset corner cases, and one full 320x240 frame.
module tb_lcd_image_streamer;
    localparam int TW = 4;
    localparam int TH = 3;
    localparam int TN = TW * TH;

    typedef struct {
        logic [15:0] data;
        logic        sof;
        logic        eol;
        logic        eof;
    } px_t;

    typedef struct {
        int pct;
        int stall;
        int pulse_at;
        int exp_lat;
    } row_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        px_ready = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data = '0;
    logic [15:0] px_data;
    logic        px_valid, px_sof, px_eol, px_eof, busy, done;

    logic        big_start = 1'b0;
    logic        big_ready = 1'b1;
    logic [16:0] big_rom_addr;
    logic [15:0] big_rom_data = '0;
    logic [15:0] big_data;
    logic        big_valid, big_sof, big_eol, big_eof, big_busy, big_done;

    int  total = 0;
    int  bad = 0;
    int  n_pop = 0;
    int  n_eol = 0;
    int  big_n = 0;
    int  big_eol_n = 0;
    int  big_err = 0;
    px_t exp_q[$];
    px_t pix_tab[TN];
    row_t rows[4];
    logic hold_chk = 1'b0;
    px_t  hold;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        rom_data     <= {8'h00, rom_addr};
        big_rom_data <= big_rom_addr[15:0];
    end

    lcd_image_streamer #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .IMG_W(TW), .IMG_H(TH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
        .px_sof(px_sof), .px_eol(px_eol), .px_eof(px_eof),
        .busy(busy), .done(done)
    );

    lcd_image_streamer big_dut (
        .clk(clk), .rst_n(rst_n), .start(big_start),
        .rom_addr(big_rom_addr), .rom_data(big_rom_data),
        .px_data(big_data), .px_valid(big_valid), .px_ready(big_ready),
        .px_sof(big_sof), .px_eol(big_eol), .px_eof(big_eof),
        .busy(big_busy), .done(big_done)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Sampled at negedge: inputs change only just after posedge, so this
    // sees exactly what the next rising edge will act on.
    task automatic monitor();
        px_t e;
        if (!rst_n) begin
            hold_chk = 1'b0;
            return;
        end
        if (hold_chk) begin
            total++;
            if (!px_valid || px_data !== hold.data || px_sof !== hold.sof ||
                px_eol !== hold.eol || px_eof !== hold.eof) begin
                bad++;
                $display("FAIL stall_hold got=%h/%b%b%b want=%h/%b%b%b", px_data, px_sof,
                         px_eol, px_eof, hold.data, hold.sof, hold.eol, hold.eof);
            end
        end
        if (px_valid && px_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pixel got=%h want=none", px_data);
            end else begin
                e = exp_q.pop_front();
                if (px_data !== e.data || px_sof !== e.sof || px_eol !== e.eol || px_eof !== e.eof) begin
                    bad++;
                    $display("FAIL pixel got=%h/%b%b%b want=%h/%b%b%b", px_data, px_sof,
                             px_eol, px_eof, e.data, e.sof, e.eol, e.eof);
                end
            end
            n_pop++;
            if (px_eol) n_eol++;
        end
        if (dut.in_flight) begin
            total++;
            if (dut.fifo_count == 3'd4) begin
                bad++;
                $display("FAIL push_full got=count4 want=count<4");
            end
        end
        hold_chk  = px_valid && !px_ready;
        hold.data = px_data;
        hold.sof  = px_sof;
        hold.eol  = px_eol;
        hold.eof  = px_eof;
        if (big_valid && big_ready) begin
            if (big_data !== big_n[15:0]) big_err++;
            if (big_eol) big_eol_n++;
            big_n++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        for (int i = 0; i < TN; i++) exp_q.push_back(pix_tab[i]);
    endtask

    task automatic wait_done(input int limit, output int lat);
        lat = -1;
        for (int k = 1; k <= limit; k++) begin
            step();
            if (done) begin
                lat = k;
                return;
            end
        end
    endtask

    task automatic run_frame(input row_t r);
        int k, p0, e0;
        logic seen;
        p0 = n_pop;
        e0 = n_eol;
        push_frame();
        start    = 1'b1;
        px_ready = (r.stall == 0);
        step();
        k = 0;
        seen = 1'b0;
        while (!seen && k < 400) begin
            start = (k == r.pulse_at);
            if (k == 1) chk("busy_run", busy, 1);
            if (r.stall > 0 && k == r.stall) begin
                chk("stall_addr", rom_addr, 3);
                chk("stall_valid", px_valid, 1);
                chk("stall_data", px_data, 0);
            end
            px_ready = (k >= r.stall) ? ($urandom_range(99) < r.pct) : 1'b0;
            step();
            k++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
        if (r.exp_lat > 0) chk("start_to_done", k, r.exp_lat);
        chk("frame_pixels", n_pop - p0, TN);
        chk("frame_eols", n_eol - e0, TH);
        chk("queue_empty", exp_q.size(), 0);
        px_ready = 1'b1;
        step();
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        int lat, k;
        for (int i = 0; i < TN; i++) begin
            pix_tab[i].data = 16'(i);
            pix_tab[i].sof  = (i == 0);
            pix_tab[i].eol  = ((i % TW) == TW - 1);
            pix_tab[i].eof  = (i == TN - 1);
        end
        rows[0] = '{pct: 100, stall: 0,  pulse_at: -1, exp_lat: TN + 2};
        rows[1] = '{pct: 50,  stall: 0,  pulse_at: -1, exp_lat: 0};
        rows[2] = '{pct: 100, stall: 20, pulse_at: -1, exp_lat: 20 + TN};
        rows[3] = '{pct: 100, stall: 0,  pulse_at: 5,  exp_lat: TN + 2};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", px_valid, 0);
        chk("rst_data", px_data, 0);
        chk("rst_tags", {px_sof, px_eol, px_eof}, 0);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_addr", rom_addr, 0);
        rst_n = 1'b1;
        step();

        for (int r = 0; r < 4; r++) run_frame(rows[r]);

        // start held high across done relaunches a frame from address 0
        push_frame();
        push_frame();
        start    = 1'b1;
        px_ready = 1'b1;
        step();
        wait_done(40, lat);
        chk("held_lat1", lat, TN + 2);
        step();
        start = 1'b0;
        chk("held_busy", busy, 1);
        chk("held_done_low", done, 0);
        wait_done(40, lat);
        chk("held_lat2", lat, TN + 2);
        chk("held_queue", exp_q.size(), 0);
        step();

        // asynchronous reset mid-frame, then a clean frame
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (!(px_valid && px_data == 16'd5) && k < 20) begin
            step();
            k++;
        end
        chk("rst_reach_px5", px_valid && px_data == 16'd5, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", px_valid, 0);
        chk("mid_rst_data", px_data, 0);
        chk("mid_rst_tags", {px_sof, px_eol, px_eof}, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", rom_addr, 0);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
        run_frame(rows[0]);

        // full-size frame on the default-parameter instance
        big_start = 1'b1;
        step();
        big_start = 1'b0;
        k = 0;
        while (!big_done && k < 80000) begin
            step();
            k++;
        end
        chk("big_start_to_done", k, 76802);
        chk("big_pixels", big_n, 76800);
        chk("big_eols", big_eol_n, 240);
        chk("big_data_errs", big_err, 0);
        chk("big_last_addr", big_rom_addr, 76799);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
